// File: rtl/button_pulse_conditioner.sv
// Button front end: synchronises and debounces six raw push-buttons, then issues each
// confirmed press as one single-cycle one-hot pulse, queuing simultaneous presses by priority.
module button_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] btn_raw,
  output logic [5:0] pulse_out,
  output logic [5:0] btn_level,
  output logic       busy
);

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] CONF_PRESS = 2'd1;
  localparam logic [1:0] HELD       = 2'd2;
  localparam logic [1:0] CONF_REL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [5:0] sync_p0;
  logic [5:0] sync_p1;
  logic [5:0] pend_set;
  logic [5:0] pending;
  logic [5:0] grant;

  // Stage p0/p1: two-flop synchroniser; everything downstream sees sync_p1 only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // Per-button debounce: a level is accepted only after DEBOUNCE_CYCLES further stable samples
  for (genvar i = 0; i < 6; i++) begin : g_btn
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             at_max;

    assign at_max = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state <= IDLE;
        cnt   <= '0;
        level <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (sync_p1[i]) begin
              state <= CONF_PRESS;
              cnt   <= '0;
            end
          end
          CONF_PRESS: begin
            if (!sync_p1[i]) begin
              state <= IDLE;
            end else if (at_max) begin
              state <= HELD;
              level <= 1'b1;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          HELD: begin
            if (!sync_p1[i]) begin
              state <= CONF_REL;
              cnt   <= '0;
            end
          end
          CONF_REL: begin
            if (sync_p1[i]) begin
              state <= HELD;
            end else if (at_max) begin
              state <= IDLE;
              level <= 1'b0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    // Only the press path arms a command; release confirmation never does
    assign pend_set[i]  = (state == CONF_PRESS) && sync_p1[i] && at_max;
    assign btn_level[i] = level;
  end

  // Stage p2: arbiter, lowest index wins (reset205 first), one pulse per cycle
  assign grant = pending & (~pending + 6'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pulse_out <= '0;
      busy      <= 1'b0;
    end else begin
      pending   <= (pending & ~grant) | pend_set;
      pulse_out <= grant;
      busy      <= |pending;
    end
  end

endmodule
